// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register carrying opaque ctrl/data bundles between two stages.
// Latency: 1 cycle in to out; full throughput of one entry per cycle.
// Backpressure: one-entry skid buffer, o_ready is registered (no i_ready->o_ready path).
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_flush             synchronous flush, drops held and incoming entries
//   i_valid/o_ready     upstream handshake, i_ctrl/i_data upstream bundles
//   o_valid/i_ready     downstream handshake, o_ctrl/o_data downstream bundles
//   o_stall_cnt         cycles with o_valid & ~i_ready (only with PIPE_STAGE_STATS_EN)
//   o_bubble_cnt        cycles with ~o_valid            (only with PIPE_STAGE_STATS_EN)
//
// Optional feature macro: PIPE_STAGE_STATS_EN (saturating 16-bit stall/bubble counters).
module pipe_stage_elastic #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              ready_q;
    logic              valid_q;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic accept, emit;
    logic load_main_in, load_main_skid, load_skid_in;

    assign accept = i_valid & ready_q;
    assign emit   = valid_q & i_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (i_flush) begin
            // Any emit this cycle still completes downstream; everything held
            // or offered is dropped.
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid_in = 1'b1;
                        state_nxt    = ST_SKID;
                    end else if (emit) begin
                        state_nxt    = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // ready_q is low here, so no accept can coincide.
                    if (emit) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_FULL;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_EMPTY;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            main_ctrl <= CTRL_RST;
            main_data <= '0;
            skid_ctrl <= CTRL_RST;
            skid_data <= '0;
        end else begin
            state   <= state_nxt;
            // Handshake outputs are registered copies of the next state.
            ready_q <= (state_nxt != ST_SKID);
            valid_q <= (state_nxt != ST_EMPTY);
            if (load_main_in) begin
                main_ctrl <= i_ctrl;
                main_data <= i_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid_in) begin
                skid_ctrl <= i_ctrl;
                skid_data <= i_data;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    // Control is forced to the no-op encoding whenever nothing is presented.
    assign o_ctrl  = valid_q ? main_ctrl : CTRL_RST;
    assign o_data  = main_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt, bubble_cnt;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (valid_q && !i_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!valid_q && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

    assign o_stall_cnt  = stall_cnt;
    assign o_bubble_cnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

    localparam int          CTRL_W   = 8;
    localparam int          DATA_W   = 16;
    localparam logic [7:0]  CRST     = 8'h5A;

    logic              i_clk = 1'b0;
    logic              i_reset, i_flush, i_valid, i_ready;
    logic              o_ready, o_valid;
    logic [CTRL_W-1:0] i_ctrl, o_ctrl;
    logic [DATA_W-1:0] i_data, o_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]       o_stall_cnt, o_bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    pipe_stage_elastic #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CRST)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_ctrl   (i_ctrl),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_ctrl   (o_ctrl),
        .o_data   (o_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .o_stall_cnt  (o_stall_cnt),
        .o_bubble_cnt (o_bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] d);
        i_valid = 1'b1;
        i_ctrl  = c;
        i_data  = d;
    endtask

    initial begin
        i_reset = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_ctrl  = '0;
        i_data  = '0;

        // Reset then idle
        tick();
        tick();
        i_reset = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_ctrl",  o_ctrl,  CRST);
        chk("rst_data",  o_data,  0);
        tick();
        chk("idle_valid", o_valid, 0);
        chk("idle_ctrl",  o_ctrl,  CRST);

        // Streaming 1..8 with downstream always ready
        i_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i + 8'h10), 16'(i));
            tick();
            chk("strm_valid", o_valid, 1);
            chk("strm_data",  o_data,  i);
            chk("strm_ctrl",  o_ctrl,  i + 8'h10);
            chk("strm_ready", o_ready, 1);
        end
        i_valid = 1'b0;
        tick();
        chk("strm_drain_valid", o_valid, 0);
        chk("strm_drain_ctrl",  o_ctrl,  CRST);

        // Back-pressure: A, B, C with downstream stalled
        i_ready = 1'b0;
        send(8'h0A, 16'hAAAA);
        tick();
        chk("bp_a_data",  o_data,  16'hAAAA);
        chk("bp_a_ready", o_ready, 1);
        send(8'h0B, 16'hBBBB);
        tick();
        chk("bp_b_data",  o_data,  16'hAAAA);
        chk("bp_b_ready", o_ready, 0);
        send(8'h0C, 16'hCCCC);
        tick();
        chk("bp_c_data",  o_data,  16'hAAAA);
        chk("bp_c_ready", o_ready, 0);
        // Release: upstream keeps offering C since it was not taken
        i_ready = 1'b1;
        tick();
        chk("bp_rel_b_data",  o_data,  16'hBBBB);
        chk("bp_rel_b_ctrl",  o_ctrl,  8'h0B);
        chk("bp_rel_b_ready", o_ready, 1);
        tick();
        chk("bp_rel_c_data",  o_data,  16'hCCCC);
        chk("bp_rel_c_valid", o_valid, 1);
        i_valid = 1'b0;
        tick();
        chk("bp_end_valid", o_valid, 0);

        // i_valid may drop without transfer: gapped stream
        send(8'h21, 16'h0021);
        tick();
        i_valid = 1'b0;
        chk("gap_1_data", o_data, 16'h0021);
        tick();
        chk("gap_hole_valid", o_valid, 0);
        send(8'h22, 16'h0022);
        tick();
        i_valid = 1'b0;
        chk("gap_2_data", o_data, 16'h0022);
        tick();

        // Flush in SKID with a new entry D offered on the flush cycle
        i_ready = 1'b0;
        send(8'h0E, 16'hEEEE);
        tick();
        send(8'h0F, 16'hFFFF);
        tick();
        chk("fl_skid_ready", o_ready, 0);
        send(8'h0D, 16'hDDDD);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", o_valid, 0);
        chk("fl_ctrl",  o_ctrl,  CRST);
        chk("fl_ready", o_ready, 1);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_d_valid", o_valid, 0);
        end

        // Flush coinciding with emit in FULL: still goes EMPTY
        send(8'h31, 16'h3131);
        tick();
        i_valid = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fl_emit_valid", o_valid, 0);
        chk("fl_emit_ready", o_ready, 1);

        // Reset while FULL and stalled
        i_ready = 1'b0;
        send(8'h47, 16'h4747);
        tick();
        chk("rf_full_data", o_data, 16'h4747);
        i_valid = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rf_valid", o_valid, 0);
        chk("rf_ctrl",  o_ctrl,  CRST);
        chk("rf_data",  o_data,  0);
        chk("rf_ready", o_ready, 1);
        i_ready = 1'b1;
        tick();
        chk("rf_after_valid", o_valid, 0);

`ifdef PIPE_STAGE_STATS_EN
        // Counters: 3 idle cycles after reset, then one stalled entry for 70000 cycles
        i_ready = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("st_rst_stall",  o_stall_cnt,  0);
        chk("st_rst_bubble", o_bubble_cnt, 0);
        tick();
        tick();
        tick();
        chk("st_idle_bubble", o_bubble_cnt, 3);
        send(8'h55, 16'h5555);
        tick();
        i_valid = 1'b0;
        chk("st_entry_bubble", o_bubble_cnt, 4);
        chk("st_entry_stall",  o_stall_cnt,  0);
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        chk("st_stall_sat", o_stall_cnt,  16'hFFFF);
        chk("st_bubble_hold", o_bubble_cnt, 4);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("st_flush_stall", o_stall_cnt, 16'hFFFF);
        tick();
        chk("st_post_fl_b1", o_bubble_cnt, 5);
        tick();
        chk("st_post_fl_b2", o_bubble_cnt, 6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque control bundle and an opaque data bundle between two pipeline stages.
- Uses a valid/ready handshake with a one-entry skid buffer, so back-pressure never creates a combinational ready path.
- Provides a synchronous flush that inserts a bubble with control forced to a safe value.

Parameters:
- CTRL_W, 16, width of the control bundle (halt, alu_op, mem_read, reg_write, ... packed by the instantiating stage).
- DATA_W, 128, width of the data bundle (read data, immediate, register indices, BDS, ...).
- CTRL_RST, {CTRL_W{1'b0}}, control value presented during reset, flush and bubbles; must encode a no-op.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous flush; drops all held and incoming entries.
- i_valid  in  1  upstream presents a valid entry.
- o_ready  out  1  stage can accept an entry; registered.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_data  in  DATA_W  upstream data bundle.
- o_valid  out  1  stage presents a valid entry downstream; registered.
- i_ready  in  1  downstream accepts this cycle.
- o_ctrl  out  CTRL_W  control bundle; equals CTRL_RST whenever o_valid=0.
- o_data  out  DATA_W  data bundle; don't-care when o_valid=0.

Behaviour:
- Definitions: accept = i_valid & o_ready. Emit = o_valid & i_ready.
- State is held in a main register (drives the outputs) and a skid register.
- States:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- o_ready is registered and equals 1 in EMPTY and FULL, 0 in SKID. No combinational path from i_ready to o_ready.
- o_valid is 1 in FULL and SKID.
- o_ctrl = o_valid ? main_ctrl : CTRL_RST. This gating is the only combinational logic on the outputs.
- Transitions:
  - EMPTY, accept: main <= input, go to FULL. Latency in to out is 1 cycle.
  - FULL, accept and emit: main <= input, stay FULL. Gives full throughput, one entry per cycle.
  - FULL, accept and no emit: skid <= input, go to SKID. Main is held unchanged.
  - FULL, emit and no accept: go to EMPTY.
  - SKID, emit: main <= skid, go to FULL. o_ready returns to 1 the next cycle.
  - SKID, no emit: hold. No accept is possible because o_ready=0.
  - Any other combination: hold.
- Ordering: entries emerge strictly in acceptance order. No entry is duplicated or dropped, except on flush or reset.
- Flush (i_flush=1; priority below reset, above everything else):
  - Next state is EMPTY, so o_valid=0, o_ready=1 and o_ctrl=CTRL_RST next cycle.
  - Any entry offered in the flush cycle is discarded, even if i_valid & o_ready.
  - Data registers may retain stale values.
- Reset (i_reset=1, highest priority):
  - State EMPTY; main and skid ctrl = CTRL_RST; data = 0.
  - Outputs after reset: o_valid=0, o_ready=1, o_ctrl=CTRL_RST, o_data=0.
  - Reset asserted mid-transfer discards all entries.
- Simultaneous flush and emit: the emit happens (downstream has already sampled the entry); the state still goes to EMPTY.
- i_valid is allowed to drop without a transfer; the stage does not require upstream to hold its entry.
- Legacy stall behaviour: tie i_valid=1 and i_ready=enable.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, adds two outputs:
  - o_stall_cnt [15:0]: counts cycles with o_valid & ~i_ready.
  - o_bubble_cnt [15:0]: counts cycles with ~o_valid.
- Both counters saturate at 16'hFFFF and are cleared only by i_reset, not by i_flush.
- When undefined, both ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: i_reset=1 for 2 cycles, then i_valid=0 -> o_valid=0, o_ready=1, o_ctrl=CTRL_RST, o_data=0.
- Streaming: i_ready=1, send data 1..8 on consecutive cycles -> o_data 1..8 appears starting 1 cycle later, no gaps, o_ready stays 1.
- Back-pressure: send A, B, C with i_ready=0 -> o_data=A held; o_ready=0 after B is accepted; C not accepted. Release i_ready -> A, B, C emerge in order, none lost.
- Flush in SKID state, with i_valid=1 and new entry D on the flush cycle -> next cycle o_valid=0, o_ctrl=CTRL_RST, o_ready=1; D never appears at the output.
- Reset while FULL with i_ready=0 -> next cycle o_valid=0, o_ctrl=CTRL_RST; the previous entry never appears at the output.
- With PIPE_STAGE_STATS_EN: hold i_ready=0 for 70000 cycles with one valid entry -> o_stall_cnt=16'hFFFF. After a flush, o_bubble_cnt increments by 1 per idle cycle.
